// File: rtl/tpu_pkg.sv
// Shared Mini TPU definitions: instruction opcodes, sequencer state encoding, default sizes.
// Latency: none (type and constant definitions only).
// Backpressure: none.
package tpu_pkg;

    // Instruction decoder opcodes
    typedef enum logic [1:0] {
        OP_START = 2'b00,
        OP_STOP  = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } opcode_t;

    // Matrix-multiply sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    localparam int DATA_WIDTH = 8;
    localparam int DEFAULT_N  = 4;

endpackage

// File: rtl/skew_decoder.sv
// Maps the sequencer step count to skewed per-lane read enables and element indices.
// Latency: purely combinational, zero cycles.
// Backpressure: i_feed low (stall or not feeding) forces all enables and indices to zero.
module skew_decoder
    import tpu_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int ELEM_W = $clog2(N),
    parameter int CNT_W  = 4
) (
    input  logic [CNT_W-1:0]    i_step,
    input  logic                i_feed,
    output logic [N-1:0]        o_read_enable,
    output logic [N*ELEM_W-1:0] o_read_elem
);

    // Lane i is live for steps i+1 .. i+N and reads element step-(i+1)
    always_comb begin
        o_read_enable = '0;
        o_read_elem   = '0;
        for (int i = 0; i < N; i++) begin
            if (i_feed && (i_step >= CNT_W'(i + 1)) && (i_step <= CNT_W'(i + N))) begin
                o_read_enable[i]                  = 1'b1;
                o_read_elem[i*ELEM_W +: ELEM_W]   = ELEM_W'(i_step - CNT_W'(i + 1));
            end
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one NxN systolic matrix multiply: clear, skewed operand feed, drain, done pulse.
// Latency: start accepted at edge k -> clear in cycle k+1, done in cycle k+3N (plus held cycles).
// Backpressure: start_ready only in IDLE; hold freezes FEED/DRAIN and masks enables; abort cancels.
module matmul_sequencer
    import tpu_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int ELEM_W = $clog2(N),
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic                abort,
    input  logic                hold,
    output logic                busy,
    output logic                done,
    output logic                array_clear,
    output logic                array_enable,
    output logic [N-1:0]        mema_read_enable,
    output logic [N*ELEM_W-1:0] mema_read_elem,
    output logic [N-1:0]        memb_read_enable,
    output logic [N*ELEM_W-1:0] memb_read_elem,
    output logic [CNT_W-1:0]    step
);

    // Step ranges of the two active phases
    localparam logic [CNT_W-1:0] C_FEED_FIRST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_FEED_LAST   = CNT_W'(2 * N - 1);
    localparam logic [CNT_W-1:0] C_DRAIN_FIRST = CNT_W'(2 * N);
    localparam logic [CNT_W-1:0] C_DRAIN_LAST  = CNT_W'(3 * N - 2);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [CNT_W-1:0]    r_step;
    logic [CNT_W-1:0]    w_next_step;
    logic                w_running;
    logic                w_stall;
    logic                w_feed;
    logic [N-1:0]        w_read_enable;
    logic [N*ELEM_W-1:0] w_read_elem;

    assign w_running = (r_state == ST_FEED) || (r_state == ST_DRAIN);
    assign w_stall   = w_running && hold;
    assign w_feed    = (r_state == ST_FEED) && !hold;

    // Next state and step: phase sequencing, hold freeze, range guard, abort override
    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_step;
        case (r_state)
            ST_IDLE: begin
                w_next_step = '0;
                if (start_valid) begin
                    w_next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_next_state = ST_FEED;
                w_next_step  = C_FEED_FIRST;
            end
            ST_FEED: begin
                if ((r_step < C_FEED_FIRST) || (r_step > C_FEED_LAST)) begin
                    w_next_state = ST_IDLE;
                    w_next_step  = '0;
                end else if (!hold) begin
                    if (r_step == C_FEED_LAST) begin
                        w_next_state = ST_DRAIN;
                        w_next_step  = C_DRAIN_FIRST;
                    end else begin
                        w_next_step = r_step + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if ((r_step < C_DRAIN_FIRST) || (r_step > C_DRAIN_LAST)) begin
                    w_next_state = ST_IDLE;
                    w_next_step  = '0;
                end else if (!hold) begin
                    if (r_step == C_DRAIN_LAST) begin
                        // step stays at the last drain value while DONE is shown
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_step = r_step + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
                w_next_step  = '0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_step  = '0;
            end
        endcase
        // abort wins over everything except reset; a start seen in IDLE is still taken
        if (abort && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
            w_next_step  = '0;
        end
    end

    // State and step registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_next_state;
            r_step  <= w_next_step;
        end
    end

    // One decoder serves both memories since their lane timing is identical
    skew_decoder #(
        .N      (N),
        .ELEM_W (ELEM_W),
        .CNT_W  (CNT_W)
    ) u_skew (
        .i_step        (r_step),
        .i_feed        (w_feed),
        .o_read_enable (w_read_enable),
        .o_read_elem   (w_read_elem)
    );

    assign start_ready      = (r_state == ST_IDLE);
    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_DONE);
    assign array_clear      = (r_state == ST_CLEAR);
    assign array_enable     = w_running && !w_stall;
    assign mema_read_enable = w_read_enable;
    assign mema_read_elem   = w_read_elem;
    assign memb_read_enable = w_read_enable;
    assign memb_read_elem   = w_read_elem;
    assign step             = r_step;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a done-cycle scoreboard.
// Latency: expected done cycle is pushed at each accepted start and popped when done appears.
// Backpressure: hold and abort/reset stimulus adjust or flush the pending expectations.
module tb_matmul_sequencer;

    localparam int N  = 4;
    localparam int EW = 2;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic          abort;
    logic          hold;
    logic          busy;
    logic          done;
    logic          array_clear;
    logic          array_enable;
    logic [N-1:0]  mema_read_enable;
    logic [N*EW-1:0] mema_read_elem;
    logic [N-1:0]  memb_read_enable;
    logic [N*EW-1:0] memb_read_elem;
    logic [CW-1:0] step;

    int checks;
    int errors;
    int cyc;
    int accepts;
    int dones;
    int last_done_cyc;
    int sb[$];

    matmul_sequencer #(.N(N), .ELEM_W(EW), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_valid      (start_valid),
        .start_ready      (start_ready),
        .abort            (abort),
        .hold             (hold),
        .busy             (busy),
        .done             (done),
        .array_clear      (array_clear),
        .array_enable     (array_enable),
        .mema_read_enable (mema_read_enable),
        .mema_read_elem   (mema_read_elem),
        .memb_read_enable (memb_read_enable),
        .memb_read_elem   (memb_read_elem),
        .step             (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; record accepts before it, score done pulses after it
    task automatic tick();
        int exp_c;
        if (start_valid && start_ready && !rst) begin
            sb.push_back(cyc + 3 * N);
            accepts++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            dones++;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_c = sb.pop_front();
                chk("done_cycle", cyc, exp_c);
            end
        end
    endtask

    function automatic logic [N-1:0] model_en(input int s);
        logic [N-1:0] en;
        en = '0;
        for (int i = 0; i < N; i++)
            if (s >= i + 1 && s <= i + N && s <= 2 * N - 1) en[i] = 1'b1;
        return en;
    endfunction

    function automatic logic [N*EW-1:0] model_el(input int s);
        logic [N*EW-1:0] el;
        el = '0;
        for (int i = 0; i < N; i++)
            if (s >= i + 1 && s <= i + N && s <= 2 * N - 1) el[i*EW +: EW] = EW'(s - (i + 1));
        return el;
    endfunction

    task automatic chk_active(input int s);
        chk("step", step, s);
        chk("array_enable", array_enable, 1);
        chk("array_clear_off", array_clear, 0);
        chk("mema_en", mema_read_enable, model_en(s));
        chk("mema_elem", mema_read_elem, model_el(s));
        chk("memb_en", memb_read_enable, model_en(s));
        chk("memb_elem", memb_read_elem, model_el(s));
    endtask

    task automatic chk_idle();
        chk("idle_ready", start_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_clear", array_clear, 0);
        chk("idle_aen", array_enable, 0);
        chk("idle_mema", {mema_read_enable, mema_read_elem}, 0);
        chk("idle_memb", {memb_read_enable, memb_read_elem}, 0);
        chk("idle_step", step, 0);
    endtask

    task automatic run_until_step(input int s);
        for (int j = 0; j < 40 && !(busy && step == CW'(s) && !array_clear); j++) tick();
        chk("reach_step", step, s);
    endtask

    task automatic wait_idle();
        for (int j = 0; j < 40 && busy; j++) tick();
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        int k;
        int d0;
        int a0;
        int d1;
        checks = 0; errors = 0; cyc = 0; accepts = 0; dones = 0; last_done_cyc = 0;
        rst = 1'b1; start_valid = 1'b0; abort = 1'b0; hold = 1'b0;

        // 1: reset then idle
        tick(); tick();
        rst = 1'b0;
        chk_idle();
        tick();
        chk_idle();

        // 2: nominal run
        k = cyc;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        chk("clear_cycle", array_clear, 1);
        chk("clear_busy", busy, 1);
        chk("clear_ready", start_ready, 0);
        chk("clear_aen", array_enable, 0);
        for (int s = 1; s <= 3 * N - 2; s++) begin
            tick();
            chk("nominal_cycle", cyc, k + 1 + s);
            chk_active(s);
        end
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_at_k12", cyc - k, 12);
        tick();
        chk_idle();

        // 3: hold for three cycles at step 3 delays done by three
        k = cyc;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        run_until_step(3);
        hold = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("hold_step", step, 3);
            chk("hold_aen", array_enable, 0);
            chk("hold_mema", mema_read_enable, 0);
            chk("hold_memb", memb_read_enable, 0);
            if (sb.size() > 0) sb[0] = sb[0] + 1;
            tick();
        end
        hold = 1'b0;
        #1;
        chk_active(3);
        d0 = dones;
        wait_idle();
        chk("hold_done_count", dones, d0 + 1);
        chk("hold_done_at_k15", last_done_cyc - k, 15);

        // 4: abort in DRAIN, then a start coinciding with abort in IDLE is taken
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        run_until_step(9);
        d0 = dones;
        abort = 1'b1;
        sb.delete();
        tick();
        abort = 1'b0;
        chk_idle();
        for (int j = 0; j < 4; j++) tick();
        chk("abort_no_done", dones, d0);
        abort = 1'b1;
        start_valid = 1'b1;
        tick();
        abort = 1'b0;
        start_valid = 1'b0;
        chk("abort_idle_start", array_clear, 1);
        wait_idle();
        chk("restart_done", dones, d0 + 1);

        // 5: start held high across a run
        a0 = accepts;
        d0 = dones;
        d1 = 0;
        start_valid = 1'b1;
        for (int j = 0; j < 40 && dones < d0 + 2; j++) begin
            tick();
            if (dones == d0 + 1 && d1 == 0) begin
                d1 = last_done_cyc;
                chk("one_accept_in_run", accepts, a0 + 1);
            end
            if (accepts == a0 + 2) start_valid = 1'b0;
        end
        start_valid = 1'b0;
        chk("b2b_done_count", dones, d0 + 2);
        chk("b2b_accepts", accepts, a0 + 2);
        chk("b2b_spacing", last_done_cyc - d1, 13);
        tick();

        // 6: reset mid-FEED
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        run_until_step(4);
        d0 = dones;
        rst = 1'b1;
        sb.delete();
        tick();
        chk_idle();
        rst = 1'b0;
        for (int j = 0; j < 15; j++) tick();
        chk("rst_no_done", dones, d0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
